stack_queue_buffer: RTL and testbench
=====================================

Name: stack_queue_buffer

Overview:
Parametrised storage buffer that runs as a LIFO stack or a FIFO queue, selected by a mode input that is latched only while the buffer is empty. It adds occupancy count, almost-full/almost-empty thresholds, sticky overflow/underflow error flags and simultaneous read/write. It is a drop-in data buffer for datapaths needing either ordering discipline from one instance.

Parameters:
DEPTH, 8, number of entries; must be at least 2 and need not be a power of two.
DATA_W, 8, data width in bits.
AFULL_TH, 6, almost_full asserts when count >= AFULL_TH.
AEMPTY_TH, 2, almost_empty asserts when count <= AEMPTY_TH.

Ports:
clk  in  1  clock; all logic acts on the rising edge.
reset  in  1  synchronous, active-low reset; the buffer resets on a rising clk edge while reset==0.
mode  in  1  0 = LIFO, 1 = FIFO; takes effect only while empty.
write  in  1  write request.
read  in  1  read request.
clear_err  in  1  clears the sticky error flags.
data_in  in  DATA_W  write data.
data_out  out  DATA_W  registered read data.
valid_out  out  1  one-cycle pulse, high when data_out was updated by a read.
count  out  $clog2(DEPTH+1)  current occupancy.
full  out  1  count==DEPTH.
empty  out  1  count==0.
almost_full  out  1  count>=AFULL_TH.
almost_empty  out  1  count<=AEMPTY_TH.
overflow  out  1  sticky; set by a dropped write.
underflow  out  1  sticky; set by an ignored read.

Behaviour:
- Reset values: count=0; all pointers=0; data_out=0; valid_out=0; overflow=0; underflow=0; active_mode<=mode. Memory contents are not cleared.
- Flags are decoded combinationally from the registered count, so they update on the edge after an operation.
- Effective mode each cycle is `mode` if count==0, else active_mode. active_mode <= effective mode every cycle, so a mode change while non-empty is ignored until the buffer drains.
- Read latency is 1: data_out and valid_out update on the same edge that accepts the read. data_out holds its value when no read is accepted; valid_out=0.
- LIFO operation:
  - A write stores at mem[sp] and increments sp.
  - A read returns mem[sp-1] and decrements sp.
- FIFO operation:
  - A write stores at mem[wr_ptr]; a read returns mem[rd_ptr].
  - Each pointer wraps from DEPTH-1 to 0.
- Simultaneous read and write, non-empty (including full):
  - Both are accepted and count is unchanged.
  - LIFO: data_out <= old top, and the top entry is replaced with data_in.
  - FIFO: the head is read and the tail is written, both pointers advance. When full, the shared location is read with its old value.
- Simultaneous read and write while empty: pass-through. data_out <= data_in, valid_out=1, count stays 0, memory is not written.
- Write while full, no read: the write is dropped, overflow<=1, state is unchanged.
- Read while empty, no write: the read is ignored, underflow<=1, valid_out=0, data_out is held.
- clear_err=1 clears overflow and underflow. If an error occurs in the same cycle, set wins.
- Reset asserted mid-operation: that edge's read/write is discarded and all registers take their reset values. Stale memory data is never observable, because count=0.

Optional Feature:
Macro STACK_QUEUE_PEEK_EN.
- Defined: adds output port peek_data [DATA_W], a combinational view of the entry the next read would return (mem[sp-1] in LIFO, mem[rd_ptr] in FIFO). peek_data is 0 when empty. It uses the effective mode.
- Not defined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then with mode=0 write 0xFF, 0x00, 0xF0, 0x0F, then issue 5 reads -> data_out 0x0F, 0xF0, 0x00, 0xFF, each with a valid_out pulse. The 5th read gives valid_out=0, underflow=1, data_out held at 0xFF. Then pulse clear_err -> underflow=0.
- Empty with mode=1, write 0x11..0x88 (8 entries) -> full=1, almost_full from count 6, count=8. A 9th write of 0x99 gives overflow=1 and count=8. Then 8 reads return 0x11..0x88 in order.
- FIFO wrap: write 6, read 6, write 6 more (0xA1..0xA6), read 6 -> data_out 0xA1..0xA6, pointers wrapped, and empty=1 at the end.
- LIFO holding 0x01, 0x02 with read+write of 0x55 -> data_out=0x02, count=2. The next read returns 0x55.
- Empty with read+write of 0x3C -> data_out=0x3C, valid_out=1, count=0, no underflow. Toggling mode while count=3 has no effect until drained.
- Mid-burst: reset=0 for one edge while write=1 and count=4 -> count=0, empty=1, valid_out=0, flags cleared. With STACK_QUEUE_PEEK_EN defined, peek_data=0.

Source files
------------

// File: rtl/stack_queue_buffer.sv
// LIFO/FIFO storage buffer with occupancy flags, sticky error flags and simultaneous read/write.
// Optional combinational peek port enabled by defining STACK_QUEUE_PEEK_EN.
module stack_queue_buffer #(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned AFULL_TH  = 6,
    parameter int unsigned AEMPTY_TH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         mode,
    input  logic                         write,
    input  logic                         read,
    input  logic                         clear_err,
    input  logic [DATA_W-1:0]            data_in,
    output logic [DATA_W-1:0]            data_out,
    output logic                         valid_out,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic                         overflow,
    output logic                         underflow
`ifdef STACK_QUEUE_PEEK_EN
    ,
    output logic [DATA_W-1:0]            peek_data
`endif
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [CNT_W-1:0]  count_q,       count_d;
    logic [CNT_W-1:0]  sp_q,          sp_d;
    logic [PTR_W-1:0]  wr_ptr_q,      wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q,      rd_ptr_d;
    logic [DATA_W-1:0] data_out_q,    data_out_d;
    logic              valid_q,       valid_d;
    logic              overflow_q,    overflow_d;
    logic              underflow_q,   underflow_d;
    logic              active_mode_q, active_mode_d;

    logic              eff_mode_c;
    logic              is_empty_c;
    logic              is_full_c;
    logic [PTR_W-1:0]  lifo_top_c;
    logic [PTR_W-1:0]  rd_addr_c;
    logic [DATA_W-1:0] rd_data_c;
    logic              mem_we_c;
    logic [PTR_W-1:0]  mem_waddr_c;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Mode input only matters while empty; otherwise the latched mode rules.
    always_comb begin
        is_empty_c = (count_q == '0);
        is_full_c  = (count_q == CNT_W'(DEPTH));
        eff_mode_c = is_empty_c ? mode : active_mode_q;
        lifo_top_c = PTR_W'(sp_q - CNT_W'(1));
        rd_addr_c  = eff_mode_c ? rd_ptr_q : lifo_top_c;
    end

    assign rd_data_c = mem_q[rd_addr_c];

    // Next-state decode for pointers, occupancy, read port and error flags.
    always_comb begin
        count_d       = count_q;
        sp_d          = sp_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        data_out_d    = data_out_q;
        valid_d       = 1'b0;
        overflow_d    = overflow_q & ~clear_err;
        underflow_d   = underflow_q & ~clear_err;
        active_mode_d = eff_mode_c;
        mem_we_c      = 1'b0;
        mem_waddr_c   = '0;

        unique case ({write, read})
            2'b11: begin
                valid_d = 1'b1;
                if (is_empty_c) begin
                    data_out_d = data_in;
                end else begin
                    data_out_d = rd_data_c;
                    mem_we_c   = 1'b1;
                    if (eff_mode_c) begin
                        mem_waddr_c = wr_ptr_q;
                        wr_ptr_d    = ptr_inc(wr_ptr_q);
                        rd_ptr_d    = ptr_inc(rd_ptr_q);
                    end else begin
                        // Top entry is read out and replaced in place.
                        mem_waddr_c = lifo_top_c;
                    end
                end
            end
            2'b10: begin
                if (is_full_c) begin
                    overflow_d = 1'b1;
                end else begin
                    mem_we_c = 1'b1;
                    count_d  = count_q + CNT_W'(1);
                    if (eff_mode_c) begin
                        mem_waddr_c = wr_ptr_q;
                        wr_ptr_d    = ptr_inc(wr_ptr_q);
                    end else begin
                        mem_waddr_c = PTR_W'(sp_q);
                        sp_d        = sp_q + CNT_W'(1);
                    end
                end
            end
            2'b01: begin
                if (is_empty_c) begin
                    underflow_d = 1'b1;
                end else begin
                    data_out_d = rd_data_c;
                    valid_d    = 1'b1;
                    count_d    = count_q - CNT_W'(1);
                    if (eff_mode_c) begin
                        rd_ptr_d = ptr_inc(rd_ptr_q);
                    end else begin
                        sp_d = sp_q - CNT_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q       <= '0;
            sp_q          <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            data_out_q    <= '0;
            valid_q       <= 1'b0;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
            active_mode_q <= mode;
        end else begin
            count_q       <= count_d;
            sp_q          <= sp_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            data_out_q    <= data_out_d;
            valid_q       <= valid_d;
            overflow_q    <= overflow_d;
            underflow_q   <= underflow_d;
            active_mode_q <= active_mode_d;
        end
    end

    // Storage array is not reset; a write in a reset cycle is discarded.
    always_ff @(posedge clk) begin
        if (reset && mem_we_c) begin
            mem_q[mem_waddr_c] <= data_in;
        end
    end

    assign data_out     = data_out_q;
    assign valid_out    = valid_q;
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
    assign full         = is_full_c;
    assign empty        = is_empty_c;
    assign almost_full  = (count_q >= CNT_W'(AFULL_TH));
    assign almost_empty = (count_q <= CNT_W'(AEMPTY_TH));

`ifdef STACK_QUEUE_PEEK_EN
    assign peek_data = is_empty_c ? '0 : rd_data_c;
`endif

endmodule

// File: tb/tb_stack_queue_buffer.sv
// Self-checking bench for stack_queue_buffer: directed plan plus random traffic vs a queue model.
// Checks peek_data too when STACK_QUEUE_PEEK_EN is defined.
module tb_stack_queue_buffer;

    localparam int unsigned DEPTH     = 8;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned AFULL_TH  = 6;
    localparam int unsigned AEMPTY_TH = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              mode;
    logic              write;
    logic              read;
    logic              clear_err;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic [3:0]        count;
    logic              full, empty, almost_full, almost_empty, overflow, underflow;
`ifdef STACK_QUEUE_PEEK_EN
    logic [DATA_W-1:0] peek_data;
`endif

    stack_queue_buffer #(
        .DEPTH(DEPTH), .DATA_W(DATA_W), .AFULL_TH(AFULL_TH), .AEMPTY_TH(AEMPTY_TH)
    ) dut (
        .clk(clk), .reset(reset), .mode(mode), .write(write), .read(read),
        .clear_err(clear_err), .data_in(data_in), .data_out(data_out),
        .valid_out(valid_out), .count(count), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .overflow(overflow), .underflow(underflow)
`ifdef STACK_QUEUE_PEEK_EN
        , .peek_data(peek_data)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: contents in arrival order; front = oldest, back = newest.
    logic [DATA_W-1:0] q[$];
    logic [DATA_W-1:0] m_data  = '0;
    logic              m_valid = 1'b0;
    logic              m_ovf   = 1'b0;
    logic              m_udf   = 1'b0;
    logic              m_act   = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int n;
        logic eff;
        logic [DATA_W-1:0] pk;
        n = q.size();
        check("data_out",     32'(data_out),     32'(m_data));
        check("valid_out",    32'(valid_out),    32'(m_valid));
        check("count",        32'(count),        32'(n));
        check("full",         32'(full),         32'(n == DEPTH));
        check("empty",        32'(empty),        32'(n == 0));
        check("almost_full",  32'(almost_full),  32'(n >= AFULL_TH));
        check("almost_empty", 32'(almost_empty), 32'(n <= AEMPTY_TH));
        check("overflow",     32'(overflow),     32'(m_ovf));
        check("underflow",    32'(underflow),    32'(m_udf));
        eff = (n == 0) ? mode : m_act;
        if (n == 0) pk = '0;
        else pk = eff ? q[0] : q[n-1];
`ifdef STACK_QUEUE_PEEK_EN
        check("peek_data", 32'(peek_data), 32'(pk));
`else
        if (pk === 'x) $display("note: model peek undefined");
`endif
    endtask

    // One functional cycle; inputs applied at negedge, outputs checked next negedge.
    task automatic step(input logic w, input logic r, input logic m, input logic ce,
                        input logic [DATA_W-1:0] d);
        logic eff;
        write = w; read = r; mode = m; clear_err = ce; data_in = d; reset = 1'b1;
        @(posedge clk);
        eff = (q.size() == 0) ? m : m_act;
        m_act = eff;
        m_valid = 1'b0;
        if (ce) begin
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end
        if (w && r) begin
            m_valid = 1'b1;
            if (q.size() == 0) begin
                m_data = d;
            end else begin
                m_data = eff ? q.pop_front() : q.pop_back();
                q.push_back(d);
            end
        end else if (w) begin
            if (q.size() == DEPTH) m_ovf = 1'b1;
            else q.push_back(d);
        end else if (r) begin
            if (q.size() == 0) begin
                m_udf = 1'b1;
            end else begin
                m_valid = 1'b1;
                m_data = eff ? q.pop_front() : q.pop_back();
            end
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic reset_step(input logic w, input logic m, input logic [DATA_W-1:0] d);
        write = w; read = 1'b0; mode = m; clear_err = 1'b0; data_in = d; reset = 1'b0;
        @(posedge clk);
        q.delete();
        m_data = '0; m_valid = 1'b0; m_ovf = 1'b0; m_udf = 1'b0; m_act = m;
        @(negedge clk);
        reset = 1'b1;
        check_all();
    endtask

    initial begin
        reset = 1'b0; mode = 1'b0; write = 1'b0; read = 1'b0; clear_err = 1'b0; data_in = '0;
        @(negedge clk);
        reset_step(1'b0, 1'b0, 8'h00);

        // LIFO ordering, underflow on the fifth read, then clear
        step(1, 0, 0, 0, 8'hFF);
        step(1, 0, 0, 0, 8'h00);
        step(1, 0, 0, 0, 8'hF0);
        step(1, 0, 0, 0, 8'h0F);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 8'h00);
        check("lifo_hold", 32'(data_out), 32'h0FF);
        check("lifo_udf", 32'(underflow), 32'd1);
        step(0, 0, 0, 1, 8'h00);
        check("udf_clear", 32'(underflow), 32'd0);

        // FIFO fill, overflow, drain
        for (int i = 1; i <= 8; i++) step(1, 0, 1, 0, 8'(i * 8'h11));
        step(1, 0, 1, 0, 8'h99);
        check("fifo_ovf", 32'(overflow), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            step(0, 1, 1, 0, 8'h00);
            check("fifo_order", 32'(data_out), 32'(i * 8'h11));
        end
        step(0, 0, 1, 1, 8'h00);

        // FIFO pointer wrap
        for (int i = 0; i < 6; i++) step(1, 0, 1, 0, 8'(8'h30 + i));
        for (int i = 0; i < 6; i++) step(0, 1, 1, 0, 8'h00);
        for (int i = 1; i <= 6; i++) step(1, 0, 1, 0, 8'(8'hA0 + i));
        for (int i = 1; i <= 6; i++) begin
            step(0, 1, 1, 0, 8'h00);
            check("wrap_order", 32'(data_out), 32'(8'hA0 + i));
        end
        check("wrap_empty", 32'(empty), 32'd1);

        // LIFO simultaneous read/write replaces the top
        step(1, 0, 0, 0, 8'h01);
        step(1, 0, 0, 0, 8'h02);
        step(1, 1, 0, 0, 8'h55);
        check("lifo_rw", 32'(data_out), 32'h02);
        step(0, 1, 0, 0, 8'h00);
        check("lifo_rw_top", 32'(data_out), 32'h55);
        step(0, 1, 0, 0, 8'h00);

        // Pass-through while empty
        step(1, 1, 1, 0, 8'h3C);
        check("passthru", 32'(data_out), 32'h3C);

        // Mode toggle ignored while non-empty
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 8'(8'hC0 + i));
        for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 8'h00);
        check("mode_lock", 32'(data_out), 32'hC0);
        step(1, 0, 1, 0, 8'hD1);
        step(1, 0, 1, 0, 8'hD2);
        step(0, 1, 0, 0, 8'h00);
        check("mode_new", 32'(data_out), 32'hD1);
        step(0, 1, 0, 0, 8'h00);

        // Reset in the middle of a burst
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 8'(8'h70 + i));
        step(0, 1, 0, 0, 8'h00);
        step(0, 1, 0, 0, 8'h00);
        step(0, 1, 0, 0, 8'h00);
        step(0, 1, 0, 0, 8'h00);
        step(0, 1, 0, 0, 8'h00);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 8'(8'h70 + i));
        reset_step(1'b1, 1'b0, 8'hEE);
        check("rst_count", 32'(count), 32'd0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic w, r, m, ce;
            w  = ($urandom_range(0, 99) < 55);
            r  = ($urandom_range(0, 99) < 45);
            m  = ($urandom_range(0, 99) < 50);
            ce = ($urandom_range(0, 99) < 5);
            if ($urandom_range(0, 199) == 0) reset_step(w, m, 8'($urandom));
            else step(w, r, m, ce, 8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
